cadence_meas: RTL and testbench
===============================

Name: cadence_meas

Overview:
- Controller that sequences the cadence filter output into a pedal-cadence measurement for the eBike torque/assist path.
- Consumes the one-cycle `cadence_rise` pulse from the cadence filter and counts prescaled timebase ticks between accepted rises.
- Publishes a saturating 8-bit period with a valid strobe, and a `not_pedaling` flag that tells assist logic when to drop to zero.
- Runs an FSM: STOPPED / FIRST / RUN, with timeout and fast-edge rejection.

Parameters:
- FAST_SIM, 0, 1 = prescaler terminal count 2^8-1 instead of 2^16-1 (simulation speed-up).
- MIN_PER, 4, minimum accepted period in ticks; faster rises are rejected.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cadence_rise  input  1  one-clk pulse on filtered cadence rising edge
- cadence_per  output  8  last accepted period in ticks; 8'hFF when stopped
- per_vld  output  1  one-clk strobe when cadence_per updates
- not_pedaling  output  1  high in STOPPED and FIRST
- timeout  output  1  one-clk strobe on RUN/FIRST -> STOPPED

Behaviour:
- Reset (rst high at posedge):
  - state=STOPPED, prescaler=0, per_cnt=0.
  - cadence_per=8'hFF, per_vld=0, not_pedaling=1, timeout=0.
  - Reset mid-measurement discards all progress.
- Prescaler:
  - 16-bit free-running counter.
  - tick=1 when prescaler[15:0]==16'hFFFF (FAST_SIM: prescaler[7:0]==8'hFF); the counter wraps to 0 after a tick.
  - The prescaler clears to 0 on every accepted rise.
- per_cnt:
  - 8-bit tick counter.
  - samp = per_cnt + tick, saturating at 255, combinational.
  - A rise exactly N*256 clks (FAST_SIM) after the previous accepted rise yields samp=N.
- Accepted rise: cadence_rise && (state==STOPPED || samp >= MIN_PER). Other rises are ignored; counters are not disturbed.
- STOPPED:
  - Accepted rise -> FIRST; clear per_cnt and prescaler. No per_vld.
- FIRST:
  - Accepted rise -> RUN; cadence_per<=samp; per_vld=1 next cycle; clear counters.
  - tick && per_cnt==255 && no rise -> STOPPED; timeout pulse.
- RUN:
  - Accepted rise -> stay RUN; cadence_per<=samp; per_vld pulse; clear counters.
  - tick && per_cnt==255 && no rise -> STOPPED; cadence_per<=8'hFF; timeout pulse.
- Output timing:
  - Outputs are registered; per_vld and timeout assert the cycle after the causing edge, for exactly 1 clk.
  - not_pedaling is registered from next-state: it is 0 only while in RUN.
- Simultaneous accepted rise and saturation: the rise wins; latch 255; stay or enter RUN; no timeout.
- per_cnt does not wrap; it holds at 255 until a rise or timeout.

Optional Feature:
- Macro: CADENCE_AVG_EN.
- Defined:
  - cadence_per is an IIR average: new = (3*cadence_per + samp + 2) >> 2, computed with 10-bit intermediate.
  - The FIRST->RUN transition loads samp directly (no averaging).
  - Timeout still forces 8'hFF.
- Undefined: cadence_per = raw samp; no averaging logic is instantiated.

Test Plan:
- rst=1 for 2 clks, then idle 70000 clks (FAST_SIM=0) -> cadence_per=8'hFF, not_pedaling=1, no per_vld, no timeout.
- FAST_SIM=1; rises every 20*256 clks, 4 rises -> first rise gives no per_vld; rises 2-4 give per_vld with cadence_per=20; not_pedaling=0 after rise 2.
- FAST_SIM=1; in RUN, extra rise 2*256 clks after an accepted rise (MIN_PER=4) -> ignored, no per_vld; next rise at 20*256 from the accepted rise gives cadence_per=20.
- FAST_SIM=1; in RUN, stop rises -> timeout pulse 256*256 clks after the last rise; cadence_per=8'hFF; not_pedaling=1; a later rise enters FIRST only.
- FAST_SIM=1; rise lands in the same cycle as saturation -> cadence_per=255, per_vld=1, timeout=0, stays RUN.
- CADENCE_AVG_EN, FAST_SIM=1; periods 20 then 40 -> cadence_per 20 then (60+40+2)>>2=25; rst asserted mid-period -> all outputs return to reset values next clk.

Source files
------------

// File: rtl/cadence_meas.sv
// Pedal cadence period measurement: STOPPED/FIRST/RUN with timeout and fast-edge reject.
// Define CADENCE_AVG_EN to make cadence_per an IIR average of accepted periods.
module cadence_meas #(
  parameter int FAST_SIM = 0,
  parameter int MIN_PER  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cadence_rise,
  output logic [7:0] cadence_per,
  output logic       per_vld,
  output logic       not_pedaling,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_FIRST,
    ST_RUN
  } state_e;

  localparam logic [7:0] MinP = 8'(MIN_PER);

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  per_q, per_d;
  logic        vld_q, vld_d;
  logic        np_q, np_d;
  logic        to_q, to_d;

  logic       tick;
  logic       sat;
  logic       accept;
  logic [7:0] samp;
  logic [7:0] run_per;

  assign tick = (FAST_SIM != 0) ? (pre_q[7:0] == 8'hFF)
                                : (pre_q == 16'hFFFF);
  assign samp = (tick && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign sat  = tick && (cnt_q == 8'hFF);

  assign accept = cadence_rise &&
                  (state_q == ST_STOP || samp >= MinP);

`ifdef CADENCE_AVG_EN
  logic [9:0] avg_sum;
  assign avg_sum = 10'd3 * {2'b00, per_q} + {2'b00, samp} + 10'd2;
  assign run_per = avg_sum[9:2];
`else
  assign run_per = samp;
`endif

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? 16'd0 : pre_q + 16'd1;
    cnt_d   = samp;
    per_d   = per_q;
    vld_d   = 1'b0;
    to_d    = 1'b0;
    if (accept) begin
      pre_d = 16'd0;
      cnt_d = 8'd0;
      unique case (state_q)
        ST_FIRST: begin
          per_d   = samp;
          vld_d   = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          per_d = run_per;
          vld_d = 1'b1;
        end
        default: state_d = ST_FIRST;
      endcase
    end else if (sat && state_q != ST_STOP) begin
      // No rise for 256 ticks: rider has stopped
      state_d = ST_STOP;
      per_d   = 8'hFF;
      cnt_d   = 8'd0;
      to_d    = 1'b1;
    end
    np_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
      pre_q   <= 16'd0;
      cnt_q   <= 8'd0;
      per_q   <= 8'hFF;
      vld_q   <= 1'b0;
      np_q    <= 1'b1;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      vld_q   <= vld_d;
      np_q    <= np_d;
      to_q    <= to_d;
    end
  end

  assign cadence_per  = per_q;
  assign per_vld      = vld_q;
  assign not_pedaling = np_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_cadence_meas.sv
// Bench for cadence_meas: elapsed-time model of four instances plus directed checks.
// Instance 0 runs FAST_SIM=0; instances 1..3 run FAST_SIM=1 in parallel.
module tb_cadence_meas;

`ifdef CADENCE_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif
  localparam int MINP = 4;

  logic       clk = 1'b0;
  logic [3:0] rise_v = 4'h0;
  logic [3:0] rst_v = 4'hF;
  logic [7:0] per_o [4];
  logic [3:0] vld_o, np_o, to_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cadence_meas #(.FAST_SIM(0), .MIN_PER(MINP)) u0 (
    .clk(clk), .rst(rst_v[0]), .cadence_rise(rise_v[0]),
    .cadence_per(per_o[0]), .per_vld(vld_o[0]),
    .not_pedaling(np_o[0]), .timeout(to_o[0]));
  cadence_meas #(.FAST_SIM(1), .MIN_PER(MINP)) u1 (
    .clk(clk), .rst(rst_v[1]), .cadence_rise(rise_v[1]),
    .cadence_per(per_o[1]), .per_vld(vld_o[1]),
    .not_pedaling(np_o[1]), .timeout(to_o[1]));
  cadence_meas #(.FAST_SIM(1), .MIN_PER(MINP)) u2 (
    .clk(clk), .rst(rst_v[2]), .cadence_rise(rise_v[2]),
    .cadence_per(per_o[2]), .per_vld(vld_o[2]),
    .not_pedaling(np_o[2]), .timeout(to_o[2]));
  cadence_meas #(.FAST_SIM(1), .MIN_PER(MINP)) u3 (
    .clk(clk), .rst(rst_v[3]), .cadence_rise(rise_v[3]),
    .cadence_per(per_o[3]), .per_vld(vld_o[3]),
    .not_pedaling(np_o[3]), .timeout(to_o[3]));

  task automatic chk(input int i, input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL u%0d %s: got %0d expected %0d", i, nm, act, exp);
    end
  endtask

  // Model: a clock-period P per tick; period = whole ticks since last accept
  int unsigned n [4];
  int unsigned last [4];
  int          mst [4];   // 0 stopped, 1 first, 2 run
  int          e_per [4];
  bit          e_vld [4], e_np [4], e_to [4], armed [4];
  int          vld_cnt0 = 0;
  int          to_cnt0 = 0;

  task automatic step(input int i);
    int unsigned el, p;
    int s;
    p = (i == 0) ? 65536 : 256;
    n[i]++;
    if (rst_v[i]) begin
      mst[i] = 0; e_per[i] = 255; e_vld[i] = 0;
      e_np[i] = 1; e_to[i] = 0; last[i] = n[i]; armed[i] = 1;
    end else begin
      el = n[i] - last[i];
      s = (el / p > 255) ? 255 : int'(el / p);
      e_vld[i] = 0;
      e_to[i] = 0;
      if (rise_v[i] && (mst[i] == 0 || s >= MINP)) begin
        if (mst[i] != 0) begin
          e_per[i] = (mst[i] == 2 && AVG) ? (3 * e_per[i] + s + 2) / 4 : s;
          e_vld[i] = 1;
          mst[i] = 2;
        end else mst[i] = 1;
        last[i] = n[i];
      end else if (mst[i] != 0 && el >= 256 * p) begin
        mst[i] = 0; e_per[i] = 255; e_to[i] = 1;
      end
      e_np[i] = (mst[i] != 2);
    end
  endtask

  always @(posedge clk)
    for (int i = 0; i < 4; i++) step(i);

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (armed[i]) begin
        chk(i, "per", int'(per_o[i]), e_per[i]);
        chk(i, "vld", int'(vld_o[i]), int'(e_vld[i]));
        chk(i, "np", int'(np_o[i]), int'(e_np[i]));
        chk(i, "to", int'(to_o[i]), int'(e_to[i]));
      end
    end
    if (vld_o[0]) vld_cnt0++;
    if (to_o[0]) to_cnt0++;
  end

  task automatic pulse(input int i);
    rise_v[i] = 1'b1;
    @(negedge clk);
    rise_v[i] = 1'b0;
  endtask

  // Rise lands k clock edges after the previous pulse's edge
  task automatic after(input int i, input int k);
    repeat (k - 1) @(negedge clk);
    pulse(i);
  endtask

  task automatic go(input int i);
    repeat (2) @(negedge clk);
    rst_v[i] = 1'b0;
  endtask

  initial begin
    fork
      begin
        go(0);
        repeat (70000) @(negedge clk);
        chk(0, "idle per", int'(per_o[0]), 255);
        chk(0, "idle np", int'(np_o[0]), 1);
        chk(0, "idle vld cnt", vld_cnt0, 0);
        chk(0, "idle to cnt", to_cnt0, 0);
      end
      begin
        go(1);
        repeat (100) @(negedge clk);
        pulse(1);
        chk(1, "r1 vld", int'(vld_o[1]), 0);
        chk(1, "r1 np", int'(np_o[1]), 1);
        for (int r = 2; r <= 4; r++) begin
          after(1, 20 * 256);
          chk(1, "run vld", int'(vld_o[1]), 1);
          chk(1, "run per", int'(per_o[1]), 20);
          chk(1, "run np", int'(np_o[1]), 0);
        end
        after(1, 2 * 256);
        chk(1, "rej vld", int'(vld_o[1]), 0);
        after(1, 18 * 256);
        chk(1, "post rej vld", int'(vld_o[1]), 1);
        chk(1, "post rej per", int'(per_o[1]), 20);
        after(1, 40 * 256);
        chk(1, "p40 per", int'(per_o[1]), AVG ? 25 : 40);
        repeat (3000) @(negedge clk);
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        chk(1, "mid rst per", int'(per_o[1]), 255);
        chk(1, "mid rst vld", int'(vld_o[1]), 0);
        chk(1, "mid rst np", int'(np_o[1]), 1);
        chk(1, "mid rst to", int'(to_o[1]), 0);
      end
      begin
        go(2);
        repeat (50) @(negedge clk);
        pulse(2);
        after(2, 20 * 256);
        repeat (65535) @(negedge clk);
        chk(2, "pre to", int'(to_o[2]), 0);
        @(negedge clk);
        chk(2, "to", int'(to_o[2]), 1);
        chk(2, "to per", int'(per_o[2]), 255);
        chk(2, "to np", int'(np_o[2]), 1);
        @(negedge clk);
        chk(2, "to width", int'(to_o[2]), 0);
        after(2, 100);
        chk(2, "restart vld", int'(vld_o[2]), 0);
        chk(2, "restart np", int'(np_o[2]), 1);
      end
      begin
        go(3);
        repeat (70) @(negedge clk);
        pulse(3);
        after(3, 20 * 256);
        after(3, 256 * 256);
        chk(3, "sat per", int'(per_o[3]), AVG ? 79 : 255);
        chk(3, "sat vld", int'(vld_o[3]), 1);
        chk(3, "sat to", int'(to_o[3]), 0);
        chk(3, "sat np", int'(np_o[3]), 0);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
